// File: rtl/bank_counter_sequencer.sv
// Control sequencer for the BANK_COUNTER_32X32 strobes: clear, N sample/accumulate beats per phase, latch, done.
// Latency: Clr 1 cycle after start, Latch N+3 (single phase) or 2N+3 (dual phase), done one cycle after Latch.
// Backpressure: stall freezes RUN_POS/RUN_NEG/DRAIN with no beat lost or repeated; start/buf_clr_req only taken in IDLE.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   start, num_samples,        run request with beat count per phase and phase mode,
//   dual_phase                 all captured when start is accepted (ready=1)
//   buf_clr_req                one BnkCtr_Buffer_Clr pulse on the next cycle, honoured in IDLE only
//   stall                      freeze request while sampling/draining
//   SA_Latch, BnkCtr_En,       array control strobes; En and comp_positive_phase come
//   BnkCtr_Clr, BnkCtr_Latch,  from a one-deep pipeline so each accumulate carries the
//   BnkCtr_Buffer_Clr,         phase of its own sample
//   comp_positive_phase
//   ready, busy, done          IDLE indicator, not-IDLE indicator, one-cycle completion pulse
module bank_counter_sequencer #(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  output logic             ready,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             dual_phase,
  input  logic             buf_clr_req,
  input  logic             stall,
  output logic             SA_Latch,
  output logic             BnkCtr_En,
  output logic             BnkCtr_Clr,
  output logic             BnkCtr_Latch,
  output logic             BnkCtr_Buffer_Clr,
  output logic             comp_positive_phase,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN_POS,
    ST_RUN_NEG,
    ST_DRAIN,
    ST_LATCH,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             dual_q, dual_d;
  logic             phase_q, phase_d;
  logic             pipe_vld_q;
  logic             pipe_ph_q;
  logic             buf_clr_q;

  logic             in_run;
  logic             stall_eff;
  logic             last_beat;
  logic             sa_latch_c;

  assign in_run     = (state_q == ST_RUN_POS) || (state_q == ST_RUN_NEG);
  assign stall_eff  = stall && (in_run || (state_q == ST_DRAIN));
  // n_q is never zero while sampling (CLR routes N=0 straight to LATCH), so N-1 cannot wrap.
  assign last_beat  = (cnt_q == (n_q - CNT_W'(1)));
  assign sa_latch_c = in_run && !stall;

  // Next-state, counter and captured-config logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dual_d  = dual_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
          n_d     = num_samples;
          dual_d  = dual_phase;
        end
      end
      ST_CLR: begin
        cnt_d   = '0;
        phase_d = 1'b1;
        state_d = (n_q == '0) ? ST_LATCH : ST_RUN_POS;
      end
      ST_RUN_POS: begin
        if (!stall) begin
          if (last_beat) begin
            cnt_d = '0;
            if (dual_q) begin
              state_d = ST_RUN_NEG;
              phase_d = 1'b0;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN_NEG: begin
        if (!stall) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          state_d = ST_LATCH;
          // Restore the positive phase now so the pipeline carries 1 back into IDLE.
          phase_d = 1'b1;
        end
      end
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      dual_q     <= 1'b0;
      phase_q    <= 1'b1;
      pipe_vld_q <= 1'b0;
      pipe_ph_q  <= 1'b1;
      buf_clr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      dual_q    <= dual_d;
      phase_q   <= phase_d;
      buf_clr_q <= (state_q == ST_IDLE) && buf_clr_req;
      // Sample-to-accumulate pipeline; holds across a stall so the pending En survives it.
      if (!stall_eff) begin
        pipe_vld_q <= sa_latch_c;
        pipe_ph_q  <= phase_q;
      end
    end
  end

  assign ready               = (state_q == ST_IDLE);
  assign busy                = (state_q != ST_IDLE);
  assign SA_Latch            = sa_latch_c;
  assign BnkCtr_En           = pipe_vld_q && !stall_eff;
  assign comp_positive_phase = pipe_ph_q;
  assign BnkCtr_Clr          = (state_q == ST_CLR);
  assign BnkCtr_Latch        = (state_q == ST_LATCH);
  assign BnkCtr_Buffer_Clr   = buf_clr_q;
  assign done                = (state_q == ST_DONE);

endmodule

// File: tb/tb_bank_counter_sequencer.sv
// Self-checking bench for bank_counter_sequencer: directed scenarios plus randomized runs.
// Expected strobe traces come from a beat-count model: every non-stalled run cycle advances
// one step; steps 0..B-1 sample, steps 1..B accumulate, Latch follows step B, done follows Latch.
module tb_bank_counter_sequencer;
  localparam int CNT_W = 10;
  localparam int MAXC  = 512;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic             ready;
  logic [CNT_W-1:0] num_samples;
  logic             dual_phase;
  logic             buf_clr_req;
  logic             stall;
  logic             SA_Latch;
  logic             BnkCtr_En;
  logic             BnkCtr_Clr;
  logic             BnkCtr_Latch;
  logic             BnkCtr_Buffer_Clr;
  logic             comp_positive_phase;
  logic             busy;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;
  bit stall_pat [MAXC];

  bank_counter_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .start               (start),
    .ready               (ready),
    .num_samples         (num_samples),
    .dual_phase          (dual_phase),
    .buf_clr_req         (buf_clr_req),
    .stall               (stall),
    .SA_Latch            (SA_Latch),
    .BnkCtr_En           (BnkCtr_En),
    .BnkCtr_Clr          (BnkCtr_Clr),
    .BnkCtr_Latch        (BnkCtr_Latch),
    .BnkCtr_Buffer_Clr   (BnkCtr_Buffer_Clr),
    .comp_positive_phase (comp_positive_phase),
    .busy                (busy),
    .done                (done)
  );

  always #5 CLK = ~CLK;

  // {SA, En, Clr, Latch, BufClr, busy, done, ready}
  function automatic logic [7:0] obs_vec();
    return {SA_Latch, BnkCtr_En, BnkCtr_Clr, BnkCtr_Latch, BnkCtr_Buffer_Clr, busy, done, ready};
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
  endtask

  // One complete run. Entered just after a rising edge with the DUT idle; returns just after
  // a rising edge with the DUT idle again. Cycle 0 is the start-accept edge.
  task automatic run_check(input int n, input bit dual, input bit bufreq, input bit inject,
                           output int done_obs);
    bit   x_sa [MAXC];
    bit   x_en [MAXC];
    bit   x_ph [MAXC];
    int   b, e, latch_c, done_c;
    logic [7:0] expv, got;
    for (int i = 0; i < MAXC; i++) begin
      x_sa[i] = 0; x_en[i] = 0; x_ph[i] = 1;
    end
    b = dual ? 2 * n : n;
    e = 0;
    latch_c = -1;
    for (int c = 2; c < MAXC - 4 && latch_c < 0; c++) begin
      if (n == 0) latch_c = 2;
      else if (!stall_pat[c]) begin
        if (e < b) x_sa[c] = 1;
        if (e >= 1) begin
          x_en[c] = 1;
          x_ph[c] = (e - 1 < n);
        end
        e++;
        if (e == b + 1) latch_c = c + 1;
      end
    end
    if (latch_c < 0) latch_c = MAXC - 4;
    done_c   = latch_c + 1;
    done_obs = -1;

    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_start: got %b want 1", ready);
    end
    start       = 1'b1;
    num_samples = CNT_W'(n);
    dual_phase  = dual;
    buf_clr_req = bufreq;
    stall       = 1'b0;
    @(posedge CLK); #1;
    start       = 1'b0;
    buf_clr_req = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      stall = stall_pat[c];
      if (inject && c <= done_c) begin
        start       = 1'($urandom_range(0, 1));
        buf_clr_req = 1'($urandom_range(0, 1));
        num_samples = CNT_W'($urandom_range(0, 20));
        dual_phase  = 1'($urandom_range(0, 1));
      end else begin
        start       = 1'b0;
        buf_clr_req = 1'b0;
      end
      @(negedge CLK);
      expv = {x_sa[c], x_en[c], (c == 1), (c == latch_c), (c == 1) && bufreq,
              (c <= done_c), (c == done_c), (c > done_c)};
      got = obs_vec();
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL strobes n=%0d dual=%0d cycle=%0d: got %b want %b (SA,En,Clr,Latch,BufClr,busy,done,ready)",
                 n, dual, c, got, expv);
      end
      if (x_en[c] || c > done_c) begin
        vectors++;
        if (comp_positive_phase !== ((c > done_c) ? 1'b1 : x_ph[c])) begin
          miscompares++;
          $display("FAIL phase n=%0d dual=%0d cycle=%0d: got %b want %b",
                   n, dual, c, comp_positive_phase, (c > done_c) ? 1'b1 : x_ph[c]);
        end
      end
      if (done === 1'b1 && done_obs < 0) done_obs = c;
      @(posedge CLK); #1;
    end
    stall       = 1'b0;
    start       = 1'b0;
    buf_clr_req = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    RESET = 1'b1; start = 1'b1; num_samples = CNT_W'(2); dual_phase = 1'b0;
    buf_clr_req = 1'b1; stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      vectors++;
      if (obs_vec() !== 8'b0000_0001 || comp_positive_phase !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state: got %b phase %b want 00000001 phase 1", obs_vec(), comp_positive_phase);
      end
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    buf_clr_req = 1'b0;
    clear_stalls();
    run_check(2, 0, 0, 0, d);
    vectors++;
    if (d !== 6) begin
      miscompares++;
      $display("FAIL first_start_after_reset: done at %0d want 6", d);
    end
  endtask

  task automatic test_single_phase();
    int d;
    clear_stalls();
    run_check(4, 0, 0, 0, d);
    vectors++;
    if (d !== 8) begin
      miscompares++;
      $display("FAIL single_phase_done: done at %0d want 8", d);
    end
  endtask

  task automatic test_dual_phase();
    int d;
    clear_stalls();
    run_check(3, 1, 0, 0, d);
    vectors++;
    if (d !== 10) begin
      miscompares++;
      $display("FAIL dual_phase_done: done at %0d want 10", d);
    end
  endtask

  task automatic test_stall();
    int d;
    clear_stalls();
    stall_pat[4] = 1'b1;
    stall_pat[5] = 1'b1;
    stall_pat[9] = 1'b1;   // the DRAIN cycle once the run has slipped by two
    run_check(5, 0, 0, 0, d);
    vectors++;
    if (d !== 12) begin
      miscompares++;
      $display("FAIL stall_done: done at %0d want 12", d);
    end
  endtask

  task automatic test_boundary();
    int d;
    clear_stalls();
    run_check(4, 0, 1, 0, d);          // start + buf_clr_req together
    run_check(6, 1, 0, 1, d);          // requests during the run are dropped
    run_check(0, 0, 0, 0, d);          // N=0
    vectors++;
    if (d !== 3) begin
      miscompares++;
      $display("FAIL n0_done: done at %0d want 3", d);
    end
    // Buffer clear alone while idle: one pulse, no run.
    buf_clr_req = 1'b1;
    @(posedge CLK); #1;
    buf_clr_req = 1'b0;
    @(negedge CLK);
    vectors++;
    if (obs_vec() !== 8'b0000_1001) begin
      miscompares++;
      $display("FAIL idle_buf_clr: got %b want 00001001", obs_vec());
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (obs_vec() !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL idle_buf_clr_single: got %b want 00000001", obs_vec());
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midrun();
    int d;
    start = 1'b1; num_samples = CNT_W'(8); dual_phase = 1'b0;
    @(posedge CLK); #1;                 // cycle 0 accept
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;                        // held during cycle 5
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if (obs_vec() !== 8'b0000_0001 || comp_positive_phase !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midrun_idle: got %b phase %b want 00000001 phase 1", obs_vec(), comp_positive_phase);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      vectors++;
      if (BnkCtr_Latch !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_midrun_quiet: latch %b done %b busy %b want 0 0 0", BnkCtr_Latch, done, busy);
      end
    end
    @(posedge CLK); #1;
    clear_stalls();
    run_check(3, 1, 0, 0, d);
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 30; it++) begin
      clear_stalls();
      for (int c = 0; c < MAXC; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
      run_check($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_phase();
    test_dual_phase();
    test_stall();
    test_boundary();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
